// File: rtl/systolic_feeder_2x2.sv
// Operand scheduler for the 2x2 MAC systolic array: loads K beats into the edge FIFOs, then issues skewed reads.
// Optional SYSTOLIC_FEEDER_CYCLE_CNT_EN adds a saturating busy-cycle counter output cycle_cnt.
module systolic_feeder_2x2 #(
  parameter int DEPTH        = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int KW           = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_row0,
  input  logic [DATA_WIDTH-1:0] s_row1,
  input  logic [DATA_WIDTH-1:0] s_col0,
  input  logic [DATA_WIDTH-1:0] s_col1,
  output logic [DATA_WIDTH-1:0] in_row_0,
  output logic [DATA_WIDTH-1:0] in_row_1,
  output logic [DATA_WIDTH-1:0] in_col_0,
  output logic [DATA_WIDTH-1:0] in_col_1,
  output logic                  row_fifo_0_w_en,
  output logic                  row_fifo_1_w_en,
  output logic                  col_fifo_0_w_en,
  output logic                  col_fifo_1_w_en,
  output logic                  row_fifo_0_r_en,
  output logic                  row_fifo_1_r_en,
  output logic                  col_fifo_0_r_en,
  output logic                  col_fifo_1_r_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef SYSTOLIC_FEEDER_CYCLE_CNT_EN
  ,
  output logic [15:0]           cycle_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [KW-1:0] DEPTH_K    = KW'(DEPTH);

  state_t                 state_q;
  logic [KW-1:0]          k_q;
  logic [KW-1:0]          beatCnt_q;
  logic [KW-1:0]          step_q;
  logic [DW-1:0]          drainCnt_q;
  logic                   sReady_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic                   wEn_q;
  logic                   rEn0_q;
  logic                   rEn1_q;
  logic [DATA_WIDTH-1:0]  inRow0_q;
  logic [DATA_WIDTH-1:0]  inRow1_q;
  logic [DATA_WIDTH-1:0]  inCol0_q;
  logic [DATA_WIDTH-1:0]  inCol1_q;

  logic kOk_d;
  logic lastBeat_d;

  assign kOk_d      = (k_len != '0) && (k_len <= DEPTH_K);
  assign lastBeat_d = (beatCnt_q == k_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      beatCnt_q  <= '0;
      step_q     <= '0;
      drainCnt_q <= '0;
      sReady_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wEn_q      <= 1'b0;
      rEn0_q     <= 1'b0;
      rEn1_q     <= 1'b0;
      inRow0_q   <= '0;
      inRow1_q   <= '0;
      inCol0_q   <= '0;
      inCol1_q   <= '0;
    end else begin
      wEn_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (kOk_d) begin
              k_q       <= k_len;
              beatCnt_q <= '0;
              sReady_q  <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (s_valid && sReady_q) begin
            inRow0_q  <= s_row0;
            inRow1_q  <= s_row1;
            inCol0_q  <= s_col0;
            inCol1_q  <= s_col1;
            wEn_q     <= 1'b1;
            beatCnt_q <= beatCnt_q + 1'b1;
            if (lastBeat_d) begin
              sReady_q <= 1'b0;
              step_q   <= '0;
              rEn0_q   <= 1'b1;
              rEn1_q   <= 1'b0;
              state_q  <= STREAM;
            end
          end
        end
        STREAM: begin
          // Row/col 1 trails row/col 0 by one step, so the pass spans K+1 steps.
          if (step_q == k_q) begin
            rEn0_q <= 1'b0;
            rEn1_q <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              drainCnt_q <= '0;
              state_q    <= DRAIN;
            end
          end else begin
            step_q <= step_q + 1'b1;
            rEn0_q <= ((step_q + 1'b1) < k_q);
            rEn1_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (drainCnt_q == DRAIN_LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            drainCnt_q <= drainCnt_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_ready         = sReady_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign in_row_0        = inRow0_q;
  assign in_row_1        = inRow1_q;
  assign in_col_0        = inCol0_q;
  assign in_col_1        = inCol1_q;
  assign row_fifo_0_w_en = wEn_q;
  assign row_fifo_1_w_en = wEn_q;
  assign col_fifo_0_w_en = wEn_q;
  assign col_fifo_1_w_en = wEn_q;
  assign row_fifo_0_r_en = rEn0_q;
  assign col_fifo_0_r_en = rEn0_q;
  assign row_fifo_1_r_en = rEn1_q;
  assign col_fifo_1_r_en = rEn1_q;

`ifdef SYSTOLIC_FEEDER_CYCLE_CNT_EN
  logic [15:0] cycleCnt_q;

  // Value in any cycle equals the busy cycles so far, the done cycle included; it then holds in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt_q <= '0;
    end else if (state_q == IDLE && start && kOk_d) begin
      cycleCnt_q <= 16'd1;
    end else if ((state_q == LOAD || state_q == STREAM || state_q == DRAIN) && cycleCnt_q != 16'hFFFF) begin
      cycleCnt_q <= cycleCnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cycleCnt_q;
`endif

endmodule

// File: doc/systolic_feeder_2x2.md
# systolic_feeder_2x2

Upstream operand scheduler for the 2x2 integer MAC systolic array. It accepts K operand beats over a valid/ready stream and writes each beat into the four edge FIFOs (row 0/1, col 0/1). It then issues the skewed FIFO read enables that wavefront the operands into the PE grid: row/col 0 first, row/col 1 one cycle later. After a fixed drain interval it pulses `done`, which tells downstream logic that `out_data_*` is valid.

## Interface
Parameters:
- `DEPTH`, 8: edge FIFO depth; maximum K.
- `DATA_WIDTH`, 16: operand width (signed).
- `DRAIN_CYCLES`, 3: cycles from the last read enable to `done`; covers FIFO read latency plus PE hops.
- `KW`, $clog2(DEPTH)+1: width of `k_len`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a new pass; sampled only in IDLE.
- `k_len`  in  KW  beats per pass; sampled with `start`.
- `s_valid`  in  1  operand beat valid.
- `s_ready`  out  1  feeder accepts a beat.
- `s_row0`, `s_row1`, `s_col0`, `s_col1`  in  DATA_WIDTH each  operand beat fields.
- `in_row_0`, `in_row_1`, `in_col_0`, `in_col_1`  out  DATA_WIDTH each  FIFO write data (registered).
- `row_fifo_0_w_en`, `row_fifo_1_w_en`, `col_fifo_0_w_en`, `col_fifo_1_w_en`  out  1  FIFO write enables.
- `row_fifo_0_r_en`, `row_fifo_1_r_en`, `col_fifo_0_r_en`, `col_fifo_1_r_en`  out  1  FIFO read enables.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at pass end.
- `err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - `start`=1 with 1 ≤ `k_len` ≤ DEPTH: latch `k_len` into K, clear the beat counter, go to LOAD.
  - `start`=1 with `k_len`=0 or `k_len`>DEPTH: pulse `err`, stay in IDLE.
- LOAD:
  - `s_ready`=1 until K beats have been accepted.
  - Each handshake (`s_valid`&`s_ready`) registers all four fields into `in_*` and asserts all four `w_en` for exactly the next cycle.
  - On the K-th handshake, `s_ready` drops in the following cycle and the FSM goes to STREAM. The last write enable coincides with the first STREAM cycle.
- STREAM: step counter t runs 0..K, so the state lasts K+1 cycles.
  - `row_fifo_0_r_en`=`col_fifo_0_r_en`=1 for t in [0,K-1].
  - `row_fifo_1_r_en`=`col_fifo_1_r_en`=1 for t in [1,K].
- DRAIN: DRAIN_CYCLES cycles with all enables low, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Outside LOAD, `s_ready`=0 and beats are ignored. Outside STREAM, all `r_en`=0. Outside the post-handshake cycle, all `w_en`=0.
- `start` while `busy`: ignored, no `err`.
- FIFO full/empty flags are not used. The range check on K ≤ DEPTH guarantees no overflow or underflow.
- Arithmetic: the data path only passes values through, bit-exact and sign-preserving. Counters are KW bits and never wrap because K ≤ DEPTH.

## Timing
- Reset values: `s_ready`, `busy`, `done`, `err`, all `w_en`, all `r_en` = 0; `in_*` = 0; state = IDLE.
- Reset asserted mid-pass forces the above state immediately (asynchronously). No `done` is produced for the aborted pass.
- Latency, with `start` at cycle 0 and back-to-back valid beats:
  - `s_ready` first high at cycle 1.
  - K-th handshake at cycle K.
  - STREAM occupies cycles K+1 .. 2K+1.
  - `done` at cycle 2K+2+DRAIN_CYCLES.
- Throughput: one beat per cycle in LOAD. Stalls on `s_valid` extend LOAD only.
- Skew between row/col 0 and row/col 1 read enables is exactly one cycle.

## Configuration
- `SYSTOLIC_FEEDER_CYCLE_CNT_EN` defined:
  - Adds output `cycle_cnt` [15:0], reset 0.
  - Cleared on an accepted `start`, incremented every cycle while `busy`, saturating at 16'hFFFF.
  - Holds its value from the `done` cycle until the next accepted `start`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- K=2, beats (1,2,3,4),(5,6,7,8), `s_valid` held high, DRAIN_CYCLES=3 -> w_en high at cycles 2 and 3 with matching `in_*`; row0/col0 `r_en` at cycles 3–4; row1/col1 `r_en` at cycles 4–5; `done` at cycle 9.
- K=8 (DEPTH) with `s_valid` toggling 1,0,1,0 -> exactly 8 writes, no ninth `w_en`; STREAM lasts 9 cycles.
- `k_len`=0, then `k_len`=9 -> `err` pulses each time; `busy` stays 0; no enables assert.
- `rst` asserted in STREAM at t=2 of K=4 -> all outputs 0 in the same cycle; no `done`; a subsequent K=1 pass completes normally.
- `start` pulsed during LOAD and during DRAIN -> ignored; no `err`; pass timing unchanged.
- With `SYSTOLIC_FEEDER_CYCLE_CNT_EN`, K=2 back-to-back -> `cycle_cnt`=9 at `done` and held in IDLE.
